// File: rtl/maze_navigator_pkg.sv
// rtl/maze_navigator_pkg.sv - shared encodings for the maze navigator
package maze_navigator_pkg;

  typedef enum logic [1:0] {
    ST_PLAY  = 2'b00,
    ST_KEYED = 2'b01,
    ST_WON   = 2'b10,
    ST_LOST  = 2'b11
  } state_t;

  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_RIGHT = 2'd1,
    DIR_DOWN  = 2'd2,
    DIR_LEFT  = 2'd3
  } dir_t;

  localparam logic [3:0] KEYPAD_UP    = 4'd2;
  localparam logic [3:0] KEYPAD_RIGHT = 4'd6;
  localparam logic [3:0] KEYPAD_DOWN  = 4'd8;
  localparam logic [3:0] KEYPAD_LEFT  = 4'd4;

  typedef struct packed {
    logic valid;
    dir_t dir;
  } move_req_t;

  function automatic move_req_t decode_keypad(input logic [3:0] code);
    move_req_t r;
    r.valid = 1'b1;
    r.dir   = DIR_UP;
    case (code)
      KEYPAD_UP:    r.dir = DIR_UP;
      KEYPAD_RIGHT: r.dir = DIR_RIGHT;
      KEYPAD_DOWN:  r.dir = DIR_DOWN;
      KEYPAD_LEFT:  r.dir = DIR_LEFT;
      default:      r.valid = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/maze_wall_lookup.sv
// rtl/maze_wall_lookup.sv - combinational move blocking (grid edge or wall bit)
module maze_wall_lookup
  import maze_navigator_pkg::*;
#(
  parameter int GRID_W = 8,
  parameter int GRID_H = 4,
  parameter int XW     = 3,
  parameter int YW     = 2
) (
  input  logic [XW-1:0]              i_posx,
  input  logic [YW-1:0]              i_posy,
  input  dir_t                       i_dir,
  input  logic [GRID_W*GRID_H*4-1:0] i_wall_map,
  output logic                       o_blocked
);

  logic [GRID_W*GRID_H*4-1:0] w_shifted;
  logic                       w_edge;
  int                         w_off;

  always_comb begin
    w_off     = (int'(i_posy) * GRID_W + int'(i_posx)) * 4 + int'(i_dir);
    w_shifted = i_wall_map >> w_off;
    w_edge    = 1'b0;
    case (i_dir)
      DIR_UP:    w_edge = (i_posy == '0);
      DIR_RIGHT: w_edge = (int'(i_posx) >= GRID_W - 1);
      DIR_DOWN:  w_edge = (int'(i_posy) >= GRID_H - 1);
      DIR_LEFT:  w_edge = (i_posx == '0);
      default:   w_edge = 1'b1;
    endcase
    o_blocked = w_edge | w_shifted[0];
  end

endmodule

// File: rtl/maze_navigator.sv
// rtl/maze_navigator.sv - keypad-driven player movement, step budget and win/lose FSM
module maze_navigator
  import maze_navigator_pkg::*;
#(
  parameter int GRID_W  = 8,
  parameter int GRID_H  = 4,
  parameter int XW      = 3,
  parameter int YW      = 2,
  parameter int STEPS   = 30,
  parameter int SW      = 5,
  parameter int START_X = 7,
  parameter int START_Y = 3,
  parameter int KEY_X   = 0,
  parameter int KEY_Y   = 3,
  parameter int EXIT_X  = 4,
  parameter int EXIT_Y  = 0,
  parameter logic [GRID_W*GRID_H*4-1:0] WALL_MAP = '0
) (
  input  logic            clk_50MHz_i,
  input  logic            rst_async_la_i,
  input  logic [3:0]      key_in,
  input  logic            enable_move,
  input  logic            new_game,
  output logic [YW+XW-1:0] address,
  output logic [SW-1:0]   step_count,
  output logic            out_of_steps,
  output logic            has_key,
  output logic            in_key_pos,
  output logic            in_exit_pos,
  output logic [1:0]      game_state,
  output logic            move_ack,
  output logic            bump
);

  if (GRID_W < 2 || GRID_W > 16 || GRID_H < 2 || GRID_H > 16 ||
      XW < $clog2(GRID_W) || YW < $clog2(GRID_H) ||
      STEPS < 1 || STEPS > (2**SW) - 1 ||
      START_X >= GRID_W || KEY_X >= GRID_W || EXIT_X >= GRID_W ||
      START_Y >= GRID_H || KEY_Y >= GRID_H || EXIT_Y >= GRID_H ||
      START_X < 0 || KEY_X < 0 || EXIT_X < 0 || START_Y < 0 || KEY_Y < 0 || EXIT_Y < 0 ||
      (START_X == KEY_X && START_Y == KEY_Y) ||
      (START_X == EXIT_X && START_Y == EXIT_Y) ||
      (KEY_X == EXIT_X && KEY_Y == EXIT_Y)) begin : g_param_err
    $error("maze_navigator: illegal parameter set");
  end

  logic            r_en_s, r_en_d;
  logic [XW-1:0]   r_posx, w_posx_nx, w_tx;
  logic [YW-1:0]   r_posy, w_posy_nx, w_ty;
  logic [SW-1:0]   r_steps, w_steps_nx;
  state_t          r_state, w_state_nx;
  logic            r_has_key, w_key_nx;
  logic            r_in_key, r_in_exit;
  logic            r_ack, w_ack_nx, r_bump, w_bump_nx;
  logic            w_fire, w_blocked;
  move_req_t       w_req;

  // Rising edge of the synchronised level: one move per press
  assign w_fire = r_en_s & ~r_en_d;
  assign w_req  = decode_keypad(key_in);

  maze_wall_lookup #(.GRID_W(GRID_W), .GRID_H(GRID_H), .XW(XW), .YW(YW)) u_wall (
    .i_posx     (r_posx),
    .i_posy     (r_posy),
    .i_dir      (w_req.dir),
    .i_wall_map (WALL_MAP),
    .o_blocked  (w_blocked)
  );

  always_comb begin
    w_tx = r_posx;
    w_ty = r_posy;
    case (w_req.dir)
      DIR_UP:    w_ty = r_posy - YW'(1);
      DIR_RIGHT: w_tx = r_posx + XW'(1);
      DIR_DOWN:  w_ty = r_posy + YW'(1);
      DIR_LEFT:  w_tx = r_posx - XW'(1);
      default:   w_tx = r_posx;
    endcase
  end

  always_comb begin
    w_posx_nx  = r_posx;
    w_posy_nx  = r_posy;
    w_steps_nx = r_steps;
    w_state_nx = r_state;
    w_key_nx   = r_has_key;
    w_ack_nx   = 1'b0;
    w_bump_nx  = 1'b0;
    if (new_game) begin
      w_posx_nx  = XW'(START_X);
      w_posy_nx  = YW'(START_Y);
      w_steps_nx = SW'(STEPS);
      w_state_nx = ST_PLAY;
      w_key_nx   = 1'b0;
    end else if (w_fire && w_req.valid && (r_state == ST_PLAY || r_state == ST_KEYED)) begin
      if (w_blocked) begin
        w_bump_nx = 1'b1;
      end else begin
        w_posx_nx  = w_tx;
        w_posy_nx  = w_ty;
        w_ack_nx   = 1'b1;
        w_steps_nx = (r_steps == '0) ? '0 : r_steps - SW'(1);
        if (r_state == ST_PLAY && w_tx == XW'(KEY_X) && w_ty == YW'(KEY_Y)) begin
          w_state_nx = ST_KEYED;
          w_key_nx   = 1'b1;
        end else if (r_state == ST_KEYED && w_tx == XW'(EXIT_X) && w_ty == YW'(EXIT_Y)) begin
          w_state_nx = ST_WON;
        end
        // Winning on the last step takes precedence over running out
        if (w_state_nx != ST_WON && w_steps_nx == '0) w_state_nx = ST_LOST;
      end
    end
  end

  always_ff @(posedge clk_50MHz_i) begin
    if (!rst_async_la_i) begin
      r_en_s    <= 1'b1;
      r_en_d    <= 1'b1;
      r_posx    <= XW'(START_X);
      r_posy    <= YW'(START_Y);
      r_steps   <= SW'(STEPS);
      r_state   <= ST_PLAY;
      r_has_key <= 1'b0;
      r_in_key  <= (START_X == KEY_X) && (START_Y == KEY_Y);
      r_in_exit <= (START_X == EXIT_X) && (START_Y == EXIT_Y);
      r_ack     <= 1'b0;
      r_bump    <= 1'b0;
    end else begin
      r_en_s    <= enable_move;
      r_en_d    <= r_en_s;
      r_posx    <= w_posx_nx;
      r_posy    <= w_posy_nx;
      r_steps   <= w_steps_nx;
      r_state   <= w_state_nx;
      r_has_key <= w_key_nx;
      r_in_key  <= (w_posx_nx == XW'(KEY_X)) && (w_posy_nx == YW'(KEY_Y));
      r_in_exit <= (w_posx_nx == XW'(EXIT_X)) && (w_posy_nx == YW'(EXIT_Y));
      r_ack     <= w_ack_nx;
      r_bump    <= w_bump_nx;
    end
  end

  assign address      = {r_posy, r_posx};
  assign step_count   = r_steps;
  assign out_of_steps = (r_steps == '0);
  assign has_key      = r_has_key;
  assign in_key_pos   = r_in_key;
  assign in_exit_pos  = r_in_exit;
  assign game_state   = r_state;
  assign move_ack     = r_ack;
  assign bump         = r_bump;

endmodule

// File: doc/maze_navigator.md
# maze_navigator

Parametrised player-movement and game-state controller for the grid maze. It converts keypad direction codes into bounded, wall-checked moves on a GRID_W × GRID_H grid and tracks a step budget. It runs a key/exit win–lose state machine and drives the cell address consumed by the display/ROM path. It sits between the keypad decoder and the video/map renderer, and generalises the fixed 8×4, 30-step, hard-coded-map controller.

## Interface

Parameters:

- GRID_W, 8, grid columns (2..16)
- GRID_H, 4, grid rows (2..16)
- XW, 3, x coordinate width, clog2(GRID_W)
- YW, 2, y coordinate width, clog2(GRID_H)
- STEPS, 30, step budget per game (1..2^SW−1)
- SW, 5, step counter width
- START_X / START_Y, 7 / 3, start cell
- KEY_X / KEY_Y, 0 / 3, key cell
- EXIT_X / EXIT_Y, 4 / 0, exit cell
- WALL_MAP, all zeros, GRID_W·GRID_H·4 bits
  - bit (y·GRID_W+x)·4+d set = move from (x,y) in direction d is blocked
  - d: 0 up, 1 right, 2 down, 3 left

Ports:

- clk_50MHz_i  in  1  system clock
- rst_async_la_i  in  1  reset, synchronous, active-low
- key_in  in  4  keypad code: 2 up, 6 right, 8 down, 4 left, others none
- enable_move  in  1  key-valid level from keypad, asynchronous to the clock
- new_game  in  1  one-cycle pulse: restart the game without reset
- address  out  YW+XW  {posy, posx} of the current cell
- step_count  out  SW  steps remaining
- out_of_steps  out  1  step_count == 0
- has_key  out  1  key collected
- in_key_pos  out  1  current cell is the key cell
- in_exit_pos  out  1  current cell is the exit cell
- game_state  out  2  00 PLAY, 01 KEYED, 10 WON, 11 LOST
- move_ack  out  1  one-cycle pulse: a move was accepted
- bump  out  1  one-cycle pulse: a move was rejected (bounds or wall)

## Operation

- **Move request:**
  - enable_move passes a synchronising flop (en_s), followed by a history flop (en_d).
  - The request fire = en_s & ~en_d; one move per press, regardless of hold time.
- **Direction:** decoded from key_in while fire is high. Code "none" gives neither move_ack nor bump.
- **Move acceptance:** accepted if and only if all of the following hold:
  - state is PLAY or KEYED;
  - the target cell is in bounds (posy>0, posy<GRID_H−1, posx>0, posx<GRID_W−1 respectively);
  - the WALL_MAP bit for the current cell and direction is clear.
- **Accepted move:** position updates, step_count decrements by 1, move_ack pulses.
- **Rejected move:** position and steps unchanged, bump pulses.
- **FSM (priority top-down, evaluated on the accepted move's target cell):**
  - PLAY, target = key cell → KEYED, has_key=1.
  - KEYED, target = exit cell → WON.
  - PLAY or KEYED, step_count becomes 0 and no win → LOST.
  - Simultaneous final step onto the exit while KEYED → WON (win beats out-of-steps).
  - Exit cell reached while in PLAY → no transition; the cell stays passable.
  - WON and LOST are terminal; fire is ignored (no ack, no bump).
- **Reset or new_game:**
  - pos = (START_X, START_Y), step_count = STEPS, has_key=0, state=PLAY.
  - move_ack=0, bump=0.
  - in_key_pos/in_exit_pos reflect the start cell.
  - new_game has priority over a coincident fire; the move is discarded.

## Timing

- All outputs are registered, and all update on the same edge as the position.
- Latency: enable_move high at edge E0 (en_d low) → fire during E0..E1 → outputs valid after E1.
- move_ack and bump are high for exactly one cycle.
- A new press is recognised only after en_s has been low for at least one cycle.
- Reset mid-game or mid-press:
  - all state returns to the reset values on that edge;
  - a press held through reset does not fire; en_d resets to 1.
- step_count never wraps below 0.

## Structure

- Shared package: state encodings, direction encodings, keypad codes.
- Sub-module `maze_wall_lookup`: combinational; takes (posx, posy, dir, WALL_MAP) and returns blocked, including the bounds check. It is reused by the renderer for wall drawing.
- Parameter checks:
  - XW/YW/SW must be wide enough for their ranges;
  - START, KEY and EXIT cells must be in range and distinct.

## Test plan

- **Reset, defaults:** address=5'b11_111, step_count=30, game_state=00, in_key_pos=0. Then press up four times → posy 2,1,0, then bump on the 4th; step_count=27.
- **Held press:** enable_move high for 100 cycles → exactly one move_ack, step_count decrements by 1.
- **Wall:** WALL_MAP blocks left at (7,3); press left → bump, address unchanged, step_count unchanged.
- **Win, KEY-then-EXIT path:** has_key rises on entering (0,3); game_state=10 on entering (4,0); further presses give no ack and no bump.
- **Budget:**
  - STEPS=3 with 3 legal moves that never reach the exit → game_state=11 after the 3rd, out_of_steps=1.
  - Same budget with the 3rd move onto the exit while KEYED → game_state=10.
- **new_game:** coincident with fire mid-game → start cell, step_count=STEPS, has_key=0, no move_ack.
